// File: rtl/buffer_arbiter_if.sv
// Producer/buffer/consumer signal bundle for buffer_arbiter.
// slave is the arbiter side; master is the surrounding logic (producers, buffer, consumer).
interface buffer_arbiter_if #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned BIT_WIDTH = 16
);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]           req;
  logic [N_REQ*BIT_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]           ack;
  logic [IDX_W-1:0]           grant_idx;
  logic                       busy;
  logic                       buf_load;
  logic [BIT_WIDTH-1:0]       buf_data_in;
  logic                       buf_full;
  logic                       buf_empty;
  logic                       rd_req;
  logic                       buf_consume;

  modport slave (
    input  req, req_data, buf_full, buf_empty, rd_req,
    output ack, grant_idx, busy, buf_load, buf_data_in, buf_consume
  );

  modport master (
    output req, req_data, buf_full, buf_empty, rd_req,
    input  ack, grant_idx, busy, buf_load, buf_data_in, buf_consume
  );
endinterface

// File: rtl/buffer_arbiter.sv
// Round-robin burst arbiter sharing one buffer write port among N_REQ producers,
// plus empty-gating of the consumer read request.
module buffer_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned BURST_LEN = 4
) (
  input logic            clk,
  input logic            rst,
  buffer_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  scan;
  logic              found;
  logic              beat;

  // First requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    owner = rr_ptr_q;
    scan  = rr_ptr_q;
    found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan = IDX_W'((32'(rr_ptr_q) + k) % N_REQ);
      if (!found && bus.req[scan]) begin
        owner = scan;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    rr_ptr_d        = rr_ptr_q;
    beat_cnt_d      = beat_cnt_q;
    beat            = 1'b0;
    bus.ack         = '0;
    bus.buf_load    = 1'b0;
    bus.busy        = 1'b0;
    bus.buf_data_in = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = owner;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        bus.busy          = 1'b1;
        bus.buf_data_in   = bus.req_data[grant_q*BIT_WIDTH +: BIT_WIDTH];
        beat              = bus.req[grant_q] & ~bus.buf_full;
        bus.buf_load      = beat;
        bus.ack[grant_q]  = beat;
        if (beat) beat_cnt_d = beat_cnt_q + CNT_W'(1);
        // A dropped request forfeits the rest of the burst.
        if ((beat && beat_cnt_q == LAST_BEAT) || !bus.req[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = IDX_W'((32'(grant_q) + 1) % N_REQ);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.grant_idx   = grant_q;
  assign bus.buf_consume = bus.rd_req & ~bus.buf_empty;
endmodule

// File: tb/tb_buffer_arbiter.sv
// Scoreboard bench for buffer_arbiter: expected loads are queued by the stimulus
// and checked by a negedge monitor whenever the DUT asserts buf_load.
module tb_buffer_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  buffer_arbiter_if #(.N_REQ(N), .BIT_WIDTH(W)) bus ();

  buffer_arbiter #(.N_REQ(N), .BIT_WIDTH(W), .BURST_LEN(BL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          idx;
    logic [15:0] data;
    int          lat;
    bit          cons;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] prod_q[N][$];
  logic [N-1:0] ack_seen = '0;
  int cyc = 0, last_cyc = 0, load_cnt = 0;
  int n_pass = 0, n_total = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Producers present the head of their word queue and request while non-empty.
  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      bus.req[i] = (prod_q[i].size() != 0);
      bus.req_data[i*W +: W] = (prod_q[i].size() != 0) ? prod_q[i][0] : 16'h0;
    end
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (ack_seen[i] && prod_q[i].size() != 0) void'(prod_q[i].pop_front());
    ack_seen = '0;
    drive();
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst === 1'b1) begin
        ack_seen = bus.ack;
        if (bus.buf_load === 1'b1) begin
          load_cnt++;
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_load: got idx %0d data 0x%0h, expected no load",
                     bus.grant_idx, bus.buf_data_in);
          end else begin
            e = exp_q.pop_front();
            check("load_idx", 32'(bus.grant_idx), e.idx);
            check("load_ack", 32'(bus.ack), 32'(1) << e.idx);
            check("load_data", 32'(bus.buf_data_in), 32'(e.data));
            if (e.lat != 0) check("load_latency", cyc - last_cyc, e.lat);
            if (e.cons) check("consume_with_load", 32'(bus.buf_consume), 1);
          end
          last_cyc = cyc;
        end else begin
          check("ack_without_load", 32'(bus.ack), 0);
        end
      end else begin
        ack_seen = '0;
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_exp(int idx, int base, int cnt, int lat0, bit cons = 1'b0);
    for (int j = 0; j < cnt; j++)
      exp_q.push_back('{idx, 16'(base + j), (j == 0) ? lat0 : 1, cons});
  endtask

  task automatic load_prod(int idx, int base, int cnt);
    for (int j = 0; j < cnt; j++) prod_q[idx].push_back(16'(base + j));
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < N; i++) prod_q[i].delete();
    drive();
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_load", 32'(bus.buf_load), 0);
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_grant", 32'(bus.grant_idx), 0);
    check("rst_data", 32'(bus.buf_data_in), 0);
    step(2);
    rst = 1'b1;
    step(1);
  endtask

  task automatic drain(string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      step();
      t++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 0);
    exp_q.delete();
    step(3);
    check({name, "_idle"}, 32'(bus.busy), 0);
  endtask

  task automatic wait_loads(string name, int n);
    int lc = load_cnt;
    int t  = 0;
    while (load_cnt < lc + n && t < 50) begin
      step();
      t++;
    end
    check({name, "_loads_seen"}, 32'(load_cnt - lc), 32'(n));
  endtask

  initial begin
    rst           = 1'b0;
    bus.req       = '0;
    bus.req_data  = '0;
    bus.buf_full  = 1'b0;
    bus.buf_empty = 1'b1;
    bus.rd_req    = 1'b0;
    do_reset();

    // Single producer: 4-beat burst, re-grant to the same owner.
    load_prod(2, 'h20, 5);
    last_cyc = cyc;
    push_exp(2, 'h20, 4, 2);
    push_exp(2, 'h24, 1, 2);
    drain("t2");
    check("t2_grant_hold", 32'(bus.grant_idx), 2);
    // rr_ptr is now 3, so idx3 beats idx0.
    load_prod(0, 'h90, 1);
    load_prod(3, 'h93, 1);
    last_cyc = cyc;
    push_exp(3, 'h93, 1, 2);
    push_exp(0, 'h90, 1, 3);
    drain("t2rr");

    // Reset mid-burst with rr_ptr=1: afterwards idx0 must win over idx2.
    load_prod(2, 'h80, 4);
    last_cyc = cyc;
    push_exp(2, 'h80, 1, 2);
    wait_loads("t1", 1);
    check("t1_busy_pre", 32'(bus.busy), 1);
    rst = 1'b0;
    #1;
    check("t1_busy_rst", 32'(bus.busy), 0);
    check("t1_load_rst", 32'(bus.buf_load), 0);
    check("t1_ack_rst", 32'(bus.ack), 0);
    load_prod(0, 'h60, 2);
    step();
    rst = 1'b1;
    last_cyc = cyc;
    push_exp(0, 'h60, 2, 2);
    push_exp(2, 'h81, 3, 3);
    drain("t1");

    // All four requesting: bursts 0,1,2,3,0.
    do_reset();
    load_prod(0, 'h1000, 8);
    load_prod(1, 'h1100, 4);
    load_prod(2, 'h1200, 4);
    load_prod(3, 'h1300, 4);
    last_cyc = cyc;
    push_exp(0, 'h1000, 4, 2);
    push_exp(1, 'h1100, 4, 2);
    push_exp(2, 'h1200, 4, 2);
    push_exp(3, 'h1300, 4, 2);
    push_exp(0, 'h1004, 4, 2);
    drain("t3");

    // Buffer full for 3 cycles after the second beat.
    do_reset();
    load_prod(1, 'h40, 4);
    last_cyc = cyc;
    push_exp(1, 'h40, 2, 2);
    push_exp(1, 'h42, 1, 4);
    push_exp(1, 'h43, 1, 1);
    wait_loads("t4", 2);
    bus.buf_full = 1'b1;
    #1;
    check("t4_busy_full", 32'(bus.busy), 1);
    check("t4_load_full", 32'(bus.buf_load), 0);
    step(3);
    bus.buf_full = 1'b0;
    drain("t4");

    // Owner idx1 drops after 2 beats; idx3 is next.
    do_reset();
    load_prod(1, 'h50, 2);
    load_prod(3, 'h70, 2);
    last_cyc = cyc;
    push_exp(1, 'h50, 2, 2);
    push_exp(3, 'h70, 2, 3);
    drain("t5");
    check("t5_grant", 32'(bus.grant_idx), 3);

    // Consume gating, including alongside loads.
    do_reset();
    bus.rd_req    = 1'b1;
    bus.buf_empty = 1'b1;
    #1;
    check("t6_consume_empty", 32'(bus.buf_consume), 0);
    bus.buf_empty = 1'b0;
    #1;
    check("t6_consume_ok", 32'(bus.buf_consume), 1);
    load_prod(2, 'h30, 2);
    last_cyc = cyc;
    push_exp(2, 'h30, 2, 2, 1'b1);
    drain("t6");
    bus.rd_req = 1'b0;
    #1;
    check("t6_consume_norq", 32'(bus.buf_consume), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "timeout");
  end
endmodule
